piso_tx: RTL and testbench

- Parallel-in, serial-out framed transmitter, UART-style: start bit, data LSB-first, stop bit.
- Accepts one word per valid/ready handshake and drives it onto a single-bit serial line at a fixed number of clocks per bit.
- Serves as the transmit end of the behavioural serial link. A companion capture/receive register stage sits at the far end of the line.

---
 rtl/piso_tx.sv | 121 ++++++++++++
 tb/tb_piso_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: UART-style framed serial transmitter.
// Accepts one word per valid/ready handshake, then sends a start bit (0),
// DATA_W data bits LSB-first, and a stop bit (1). Each bit is held for
// CLKS_PER_BIT clocks. All outputs are registered.
module piso_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic              bit_done;

    // Next shift value and end-of-bit-period flag.
    // The line is driven from the shifted value so the new bit appears
    // on the same edge that the shift register advances.
    always_comb begin
        shreg_nxt = shreg >> 1;
        bit_done  = (div_cnt == DIV_LAST);
    end

    // Frame sequencer with registered line, ready and busy outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            tx_serial <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    if (tx_valid) begin
                        shreg     <= tx_data;
                        state     <= START;
                        tx_serial <= 1'b0;
                        tx_ready  <= 1'b0;
                        tx_busy   <= 1'b1;
                    end
                end

                START: begin
                    if (bit_done) begin
                        div_cnt   <= '0;
                        state     <= DATA;
                        tx_serial <= shreg[0];
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        div_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt   <= '0;
                            state     <= STOP;
                            tx_serial <= 1'b1;
                        end else begin
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            shreg     <= shreg_nxt;
                            tx_serial <= shreg_nxt[0];
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        div_cnt   <= '0;
                        state     <= IDLE;
                        tx_serial <= 1'b1;
                        tx_ready  <= 1'b1;
                        tx_busy   <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                default: begin
                    state     <= IDLE;
                    div_cnt   <= '0;
                    bit_cnt   <= '0;
                    tx_serial <= 1'b1;
                    tx_ready  <= 1'b1;
                    tx_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx: randomized and directed stimulus checked against
// a frame-position reference model (expected line level derived from the
// position inside the frame, not from any state machine).
module tb_piso_tx;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int FRAME = (DW + 2) * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx_serial;
    logic          tx_busy;

    int errors = 0;
    int checks = 0;

    // Reference model: pos = clocks since accept edge (-1 when idle).
    int            pos = -1;
    logic [DW-1:0] mword = '0;
    logic [2:0]    exp3;          // {serial, ready, busy}

    piso_tx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_serial(tx_serial),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    // Line level at a frame position: start 0, data LSB-first, stop 1.
    function automatic logic exp_line(int p, logic [DW-1:0] w);
        int idx;
        if (p < 0) return 1'b1;
        idx = p / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= DW) return w[idx-1];
        return 1'b1;
    endfunction

    // Advance one clock, update the model, settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            pos = -1;
        end else if (pos < 0) begin
            if (tx_valid) begin
                pos   = 0;
                mword = tx_data;
            end
        end else begin
            pos = pos + 1;
            if (pos == FRAME) pos = -1;
        end
        #1;
        exp3 = (pos < 0) ? 3'b110 : {exp_line(pos, mword), 2'b01};
    endtask

    task automatic test_reset();
        #1;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        rst      = 1'b0;
        #1;
        if ({tx_serial, tx_ready, tx_busy} !== 3'b110) begin
            errors++;
            $display("FAIL reset_async got=%b want=110", {tx_serial, tx_ready, tx_busy});
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({tx_serial, tx_ready, tx_busy} !== 3'b110) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%b want=110", i, {tx_serial, tx_ready, tx_busy});
            end
            checks++;
        end
        tx_valid = 1'b0;
        rst      = 1'b1;
        tick();
        if ({tx_serial, tx_ready, tx_busy} !== 3'b110) begin
            errors++;
            $display("FAIL reset_release got=%b want=110", {tx_serial, tx_ready, tx_busy});
        end
        checks++;
    endtask

    task automatic test_single_frame();
        int         busy_cnt = 0;
        int         ready_at = -1;
        logic [9:0] seen = '0;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = $urandom;
        for (int e = 0; e < FRAME + 4; e++) begin
            if (e > 0) tick();
            if ({tx_serial, tx_ready, tx_busy} !== exp3) begin
                errors++;
                $display("FAIL single_model e=%0d got=%b want=%b", e, {tx_serial, tx_ready, tx_busy}, exp3);
            end
            checks++;
            if (tx_busy === 1'b1) busy_cnt++;
            if (tx_ready === 1'b1 && ready_at < 0) ready_at = e;
            if (e < FRAME && (e % CPB) == CPB / 2) seen[e/CPB] = tx_serial;
        end
        if (seen !== {1'b1, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL single_bits got=%b want=%b", seen, {1'b1, 8'hA5, 1'b0});
        end
        checks++;
        if (busy_cnt != 40) begin
            errors++;
            $display("FAIL single_busy_len got=%0d want=40", busy_cnt);
        end
        checks++;
        if (ready_at != 40) begin
            errors++;
            $display("FAIL single_ready_edge got=%0d want=40", ready_at);
        end
        checks++;
    endtask

    task automatic test_data_stability();
        logic [DW-1:0] bits = '0;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        for (int e = 0; e < FRAME + 2; e++) begin
            if (e > 0) tick();
            if ({tx_serial, tx_ready, tx_busy} !== exp3) begin
                errors++;
                $display("FAIL stable_model e=%0d got=%b want=%b", e, {tx_serial, tx_ready, tx_busy}, exp3);
            end
            checks++;
            if (e >= CPB && e < (DW + 1) * CPB && (e % CPB) == CPB / 2)
                bits[e/CPB-1] = tx_serial;
        end
        if (bits !== 8'h3C) begin
            errors++;
            $display("FAIL stable_bits got=%h want=3c", bits);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int            second_at = -1;
        int            idle_cnt  = 0;
        logic          prev_busy;
        logic [9:0]    seen2 = '0;
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        tick();
        tx_data   = 8'h80;
        prev_busy = tx_busy;
        for (int e = 1; e < 2 * FRAME + 4; e++) begin
            tick();
            if ({tx_serial, tx_ready, tx_busy} !== exp3) begin
                errors++;
                $display("FAIL b2b_model e=%0d got=%b want=%b", e, {tx_serial, tx_ready, tx_busy}, exp3);
            end
            checks++;
            if (second_at < 0 && tx_ready === 1'b1) idle_cnt++;
            if (second_at < 0 && prev_busy === 1'b0 && tx_busy === 1'b1) begin
                second_at = e;
                tx_valid  = 1'b0;
            end
            if (second_at >= 0 && e - second_at < FRAME && ((e - second_at) % CPB) == CPB / 2)
                seen2[(e-second_at)/CPB] = tx_serial;
            prev_busy = tx_busy;
        end
        tx_valid = 1'b0;
        if (second_at != FRAME + 1) begin
            errors++;
            $display("FAIL b2b_second_start got=%0d want=%0d", second_at, FRAME + 1);
        end
        checks++;
        if (idle_cnt != 1) begin
            errors++;
            $display("FAIL b2b_idle_gap got=%0d want=1", idle_cnt);
        end
        checks++;
        if (seen2 !== {1'b1, 8'h80, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second_bits got=%b want=%b", seen2, {1'b1, 8'h80, 1'b0});
        end
        checks++;
    endtask

    task automatic test_ignored_request();
        int         rises = 0;
        logic       prev_busy;
        logic [9:0] seen = '0;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        tx_valid  = 1'b0;
        prev_busy = tx_busy;
        for (int e = 1; e < FRAME + 20; e++) begin
            if (e == 3 * CPB + 1) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end else begin
                tx_valid = 1'b0;
            end
            tick();
            if ({tx_serial, tx_ready, tx_busy} !== exp3) begin
                errors++;
                $display("FAIL ignore_model e=%0d got=%b want=%b", e, {tx_serial, tx_ready, tx_busy}, exp3);
            end
            checks++;
            if (e < FRAME && (e % CPB) == CPB / 2) seen[e/CPB] = tx_serial;
            if (prev_busy === 1'b0 && tx_busy === 1'b1) rises++;
            prev_busy = tx_busy;
        end
        if (seen !== {1'b1, 8'h55, 1'b0}) begin
            errors++;
            $display("FAIL ignore_bits got=%b want=%b", seen, {1'b1, 8'h55, 1'b0});
        end
        checks++;
        if (rises != 0) begin
            errors++;
            $display("FAIL ignore_no_frame got=%0d starts want=0", rises);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        // Run into the 4th data bit (frame bit index 4).
        while (pos >= 0 && pos < 4 * CPB + 1) tick();
        #2;
        rst = 1'b0;
        pos = -1;
        #1;
        if ({tx_serial, tx_ready, tx_busy} !== 3'b110) begin
            errors++;
            $display("FAIL async_reset_mid got=%b want=110", {tx_serial, tx_ready, tx_busy});
        end
        checks++;
        tick();
        tick();
        rst = 1'b1;
        for (int e = 0; e < 2 * FRAME; e++) begin
            tick();
            if ({tx_serial, tx_ready, tx_busy} !== 3'b110) begin
                errors++;
                $display("FAIL async_after_release e=%0d got=%b want=110", e, {tx_serial, tx_ready, tx_busy});
            end
            checks++;
        end
        // A fresh frame must start cleanly from cleared counters.
        tx_data  = DW'($urandom);
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int e = 0; e < FRAME + 2; e++) begin
            if (e > 0) tick();
            if ({tx_serial, tx_ready, tx_busy} !== exp3) begin
                errors++;
                $display("FAIL async_next_frame e=%0d got=%b want=%b", e, {tx_serial, tx_ready, tx_busy}, exp3);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = DW'($urandom);
            tick();
            if ({tx_serial, tx_ready, tx_busy} !== exp3) begin
                errors++;
                $display("FAIL random i=%0d got=%b want=%b", i, {tx_serial, tx_ready, tx_busy}, exp3);
            end
            checks++;
            if (tx_busy !== ~tx_ready) begin
                errors++;
                $display("FAIL random_busy_ready i=%0d busy=%b ready=%b", i, tx_busy, tx_ready);
            end
            checks++;
        end
        tx_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_data_stability();
        test_back_to_back();
        test_ignored_request();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
